// File: rtl/mem_copy_dma_if.sv
// mem_copy_dma_if: single-port RAM bus between the copy engine (master) and a dual-port RAM port (slave)
interface mem_copy_dma_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-by-word memory copy engine, one read and one write cycle per word on a single RAM port
module mem_copy_dma #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [15:0]       len,
    output logic              busy,
    output logic              done,
    mem_copy_dma_if.master    mem
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       len_q;
    logic [15:0]       i_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_en_q;
    logic [15:0]       i_inc_d;
    logic              last_d;

    // i never exceeds len-1, so i+1 cannot overflow the 16-bit index
    assign i_inc_d = i_q + 16'd1;
    assign last_d  = !(i_inc_d < len_q);

    // Copy sequencer: READ presents the source address, WRITE presents the destination while RAM data is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            i_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != 16'd0) begin
                            src_q      <= src_addr;
                            dst_q      <= dst_addr;
                            len_q      <= len;
                            i_q        <= '0;
                            busy_q     <= 1'b1;
                            mem_addr_q <= src_addr;
                            mem_en_q   <= 1'b0;
                            state_q    <= READ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_addr_q <= dst_q + ADDR_W'(i_q);
                    mem_en_q   <= 1'b1;
                    state_q    <= WRITE;
                end
                WRITE: begin
                    mem_en_q <= 1'b0;
                    if (!last_d) begin
                        i_q        <= i_inc_d;
                        mem_addr_q <= src_q + ADDR_W'(i_inc_d);
                        state_q    <= READ;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem.mem_en    = mem_en_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_en_q ? mem.mem_rdata : '0;
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: scoreboard bench with a behavioural RAM and a sequential word-copy reference model
module tb_mem_copy_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic [15:0] ram     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [31:0] exp_q [$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          busy_cnt = 0;
    int          en_cnt   = 0;
    int          done_cnt = 0;
    int          b0, e0, d0;

    mem_copy_dma_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

    mem_copy_dma #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src),
        .dst_addr (dst),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    // RAM with registered read; engine writes take priority over bench preloads
    always @(posedge clk) begin
        if (mem_bus.mem_en) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        else if (ld_en) ram[ld_addr] <= ld_data;
        mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (busy) busy_cnt++;
                if (done) done_cnt++;
                if (mem_bus.mem_en) begin
                    en_cnt++;
                    chk("en_implies_busy", busy, 1);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_write: addr %h data %h with nothing expected", mem_bus.mem_addr, mem_bus.mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", mem_bus.mem_addr, e[31:16]);
                        chk("write_data", mem_bus.mem_wdata, e[15:0]);
                    end
                end else begin
                    chk("wdata_idle", mem_bus.mem_wdata, 0);
                end
            end
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        ref_mem[a] = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic snap();
        b0 = busy_cnt;
        e0 = en_cnt;
        d0 = done_cnt;
    endtask

    task automatic stats(input int eb, input int ee, input int ed);
        step();
        step();
        chk("busy_cycles", busy_cnt - b0, eb);
        chk("en_cycles", en_cnt - e0, ee);
        chk("done_cycles", done_cnt - d0, ed);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    // Start a copy; the model copies nwr words in ascending order so overlaps see prior writes
    task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input int nwr);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        for (int i = 0; i < nwr; i++) begin
            logic [15:0] sa, da;
            sa = s + 16'(i);
            da = d + 16'(i);
            ref_mem[da] = ref_mem[sa];
            exp_q.push_back({da, ref_mem[da]});
        end
        step();
        start = 1'b0;
        src   = 16'($urandom);
        dst   = 16'($urandom);
        len   = 16'($urandom);
        chk("busy_after_start", busy, l != 0);
        chk("done_after_start", done, l == 0);
    endtask

    task automatic wait_done(input int lat);
        int n = 0;
        while (done !== 1'b1 && n < lat + 6) begin
            step();
            n++;
        end
        chk("done_latency", n, lat);
        chk("busy_in_done_cycle", busy, 0);
    endtask

    task automatic region(input logic [15:0] d, input int l);
        for (int i = 0; i < l; i++) chk("dst_word", ram[d + 16'(i)], ref_mem[d + 16'(i)]);
    endtask

    initial begin
        logic [15:0] s, d, l;
        reset = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        fork
            monitor();
        join_none
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_bus.mem_en, 0);
        chk("rst_mem_addr", mem_bus.mem_addr, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), 16'hA001 + 16'(i));
        snap();
        issue(16'h0100, 16'h0200, 16'd4, 4);
        wait_done(8);
        stats(8, 4, 1);
        for (int i = 0; i < 4; i++) chk("basic_dst", ram[16'h0200 + 16'(i)], 16'hA001 + 16'(i));

        snap();
        issue(16'h0300, 16'h0310, 16'd0, 0);
        step();
        chk("zero_done_drops", done, 0);
        stats(0, 0, 1);

        poke(16'hFFFE, 16'h1111);
        poke(16'hFFFF, 16'h2222);
        poke(16'h0000, 16'h3333);
        snap();
        issue(16'hFFFE, 16'h0010, 16'd3, 3);
        wait_done(6);
        stats(6, 3, 1);
        chk("wrap_0", ram[16'h0010], 16'h1111);
        chk("wrap_1", ram[16'h0011], 16'h2222);
        chk("wrap_2", ram[16'h0012], 16'h3333);

        poke(16'h0040, 16'h00AA);
        poke(16'h0041, 16'h0BB1);
        poke(16'h0042, 16'h0CC2);
        snap();
        issue(16'h0040, 16'h0041, 16'd3, 3);
        wait_done(6);
        stats(6, 3, 1);
        for (int i = 1; i < 4; i++) chk("overlap_dst", ram[16'h0040 + 16'(i)], 16'h00AA);

        for (int i = 0; i < 8; i++) poke(16'h0500 + 16'(i), 16'($urandom));
        for (int i = 0; i < 8; i++) poke(16'h0600 + 16'(i), 16'($urandom));
        snap();
        issue(16'h0500, 16'h0600, 16'd8, 2);
        repeat (4) step();
        reset = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_mem_en", mem_bus.mem_en, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_addr", mem_bus.mem_addr, 0);
        reset = 1'b0;
        repeat (4) step();
        stats(5, 2, 0);
        region(16'h0600, 8);

        for (int i = 0; i < 6; i++) poke(16'h0700 + 16'(i), 16'($urandom));
        for (int i = 0; i < 3; i++) poke(16'h0900 + 16'(i), 16'($urandom));
        snap();
        issue(16'h0700, 16'h0800, 16'd6, 6);
        start = 1'b1;
        src   = 16'h0900;
        dst   = 16'h0A00;
        len   = 16'd3;
        step();
        step();
        start = 1'b0;
        wait_done(10);
        issue(16'h0900, 16'h0A00, 16'd3, 3);
        wait_done(6);
        stats(18, 9, 2);
        region(16'h0800, 6);
        region(16'h0A00, 3);

        for (int k = 0; k < 6; k++) begin
            s = 16'($urandom);
            d = 16'($urandom);
            l = 16'($urandom_range(1, 10));
            for (int i = 0; i < int'(l); i++) poke(s + 16'(i), 16'($urandom));
            snap();
            issue(s, d, l, int'(l));
            wait_done(2 * int'(l));
            stats(2 * int'(l), int'(l), 1);
            region(d, int'(l));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
